// File: rtl/score_accumulator.sv
// Output-layer score builder: sums ACC_LEN signed partial products per class (10 classes) with
// saturation, and presents the packed frame of scores on Num under a valid/ready handshake.
module score_accumulator #(
   parameter int NUM_SIZE = 26,
   parameter int IN_SIZE  = 16,
   parameter int ACC_LEN  = 4
) (
   input  logic                       clk,
   input  logic                       GlobalReset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [IN_SIZE-1:0]  in_data,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_SIZE*10-1:0]     Num,
   output logic                       err_last
);

   localparam int BEAT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(ACC_LEN - 1);
   localparam logic [3:0] CLS_MAX = 4'd9;
   localparam logic signed [NUM_SIZE-1:0] SAT_MAX = {1'b0, {(NUM_SIZE-1){1'b1}}};
   localparam logic signed [NUM_SIZE-1:0] SAT_MIN = {1'b1, {(NUM_SIZE-1){1'b0}}};

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   // Overflow shows up as disagreement between the two top bits of the widened sum.
   function automatic logic signed [NUM_SIZE-1:0] sat(input logic signed [NUM_SIZE:0] v);
      if (v[NUM_SIZE] != v[NUM_SIZE-1]) begin
         sat = v[NUM_SIZE] ? SAT_MIN : SAT_MAX;
      end else begin
         sat = v[NUM_SIZE-1:0];
      end
   endfunction

   state_t                      r_state;
   state_t                      w_state_next;
   logic [BEAT_W-1:0]           r_beat;
   logic [3:0]                  r_cls;
   logic signed [NUM_SIZE-1:0]  r_acc;
   logic [NUM_SIZE-1:0]         r_slot [10];
   logic                        r_err_last;

   logic                        w_in_hs;
   logic                        w_last_beat;
   logic                        w_final;
   logic signed [NUM_SIZE:0]    w_x;
   logic signed [NUM_SIZE:0]    w_sum_wide;
   logic signed [NUM_SIZE-1:0]  w_acc_next;

   assign in_ready    = (r_state == ST_ACCUM);
   assign out_valid   = (r_state == ST_HOLD);
   assign err_last    = r_err_last;

   assign w_in_hs     = in_valid & in_ready;
   assign w_last_beat = (r_beat == BEAT_MAX);
   assign w_final     = w_last_beat & (r_cls == CLS_MAX);
   assign w_x         = {{(NUM_SIZE + 1 - IN_SIZE){in_data[IN_SIZE-1]}}, in_data};
   assign w_sum_wide  = {r_acc[NUM_SIZE-1], r_acc} + w_x;
   // First beat of a class loads; with ACC_LEN==1 every beat is a first beat.
   assign w_acc_next  = (r_beat == '0) ? w_x[NUM_SIZE-1:0] : sat(w_sum_wide);

   genvar k;
   generate
      for (k = 0; k < 10; k++) begin : g_pack
         assign Num[k*NUM_SIZE +: NUM_SIZE] = r_slot[k];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_ACCUM: begin
            if (w_in_hs && w_final) begin
               w_state_next = ST_HOLD;
            end else begin
               w_state_next = ST_ACCUM;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               w_state_next = ST_ACCUM;
            end else begin
               w_state_next = ST_HOLD;
            end
         end
         default: w_state_next = ST_ACCUM;
      endcase
   end

   // Beat/class counters, running accumulator, score slots and framing check.
   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         r_beat     <= '0;
         r_cls      <= 4'd0;
         r_acc      <= '0;
         r_err_last <= 1'b0;
         for (int i = 0; i < 10; i++) begin
            r_slot[i] <= '0;
         end
      end else begin
         r_err_last <= w_in_hs & (in_last ^ w_final);
         if (w_in_hs) begin
            r_acc <= w_acc_next;
            if (w_last_beat) begin
               r_slot[r_cls] <= w_acc_next;
               r_beat        <= '0;
               r_cls         <= w_final ? 4'd0 : r_cls + 4'd1;
            end else begin
               r_beat <= r_beat + BEAT_W'(1);
            end
         end
      end
   end

endmodule
